// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz timing constants for the VGA display path.
// Used by vga_sync and by the sprite/map renderer so both agree on geometry.
package vga_timing_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Coordinates are always 10 bits wide; larger timings cannot be represented.
  localparam int COORD_W = 10;

  // 640x480 uses negative sync pulses.
  localparam logic VGA_SYNC_POL = 1'b0;

  typedef logic [COORD_W-1:0] coord_t;

  // True when lo <= v < hi.
  function automatic logic in_window(input coord_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Timing bundle from vga_sync to its consumers (renderer, VGA pins).
// frame_tick exists only when VGA_FRAME_TICK_EN is defined.
interface vga_sync_if;
  import vga_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   video_on;
  coord_t pix_x;
  coord_t pix_y;
`ifdef VGA_FRAME_TICK_EN
  logic   frame_tick;
`endif

  modport master (
`ifdef VGA_FRAME_TICK_EN
    output frame_tick,
`endif
    output hsync,
    output vsync,
    output video_on,
    output pix_x,
    output pix_y
  );

  modport slave (
`ifdef VGA_FRAME_TICK_EN
    input  frame_tick,
`endif
    input  hsync,
    input  vsync,
    input  video_on,
    input  pix_x,
    input  pix_y
  );

endinterface

// File: rtl/vga_mod_counter.sv
// Modulo-MOD up counter with enable. Reset parks it at MOD-1 so the first
// enabled edge after reset lands on 0. wrap is high on the enabled edge that
// takes the count from MOD-1 back to 0; count_nxt is the value after that edge.
module vga_mod_counter #(
  parameter int MOD = 800,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] count_r;
  logic [W-1:0] count_nxt_s;
  logic         wrap_s;

  // next count value and terminal-count detect
  always_comb begin
    count_nxt_s = count_r;
    wrap_s      = 1'b0;
    if (en) begin
      if (count_r == LAST) begin
        count_nxt_s = {W{1'b0}};
        wrap_s      = 1'b1;
      end else begin
        count_nxt_s = count_r + W'(1);
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // count register, parked at MOD-1 in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= LAST;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count     = count_r;
  assign count_nxt = count_nxt_s;
  assign wrap      = wrap_s;

endmodule

// File: rtl/vga_sync.sv
// VGA 640x480@60Hz timing generator, clocked by the 25 MHz pixel clock.
// All outputs are registers; sync/blank flags are decoded from the counters'
// next value so they describe the coordinate presented in the same cycle.
// Optional: define VGA_FRAME_TICK_EN to add the frame_tick pulse output.
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE = VGA_H_VISIBLE,
  parameter int   H_FRONT   = VGA_H_FRONT,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BACK    = VGA_H_BACK,
  parameter int   V_VISIBLE = VGA_V_VISIBLE,
  parameter int   V_FRONT   = VGA_V_FRONT,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BACK    = VGA_V_BACK,
  parameter logic SYNC_POL  = VGA_SYNC_POL
) (
  input  logic       clk_25mhz,
  input  logic       rst,
  vga_sync_if.master vid
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  // Counters are fixed at COORD_W bits; reject timings that do not fit.
  if ((H_TOTAL > (1 << COORD_W)) || (V_TOTAL > (1 << COORD_W))) begin : g_bad_timing
    $error("vga_sync: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
  end

  coord_t x_s;
  coord_t y_s;
  coord_t x_nxt_s;
  coord_t y_nxt_s;
  logic   h_wrap_s;
  logic   v_wrap_s;

  logic   hsync_nxt_s;
  logic   vsync_nxt_s;
  logic   video_on_nxt_s;
  logic   hsync_r;
  logic   vsync_r;
  logic   video_on_r;

  vga_mod_counter #(.MOD(H_TOTAL), .W(COORD_W)) u_h_cnt (
    .clk       (clk_25mhz),
    .rst       (rst),
    .en        (1'b1),
    .count     (x_s),
    .count_nxt (x_nxt_s),
    .wrap      (h_wrap_s)
  );

  // The line counter only advances when the pixel counter wraps, so y (and
  // therefore vsync) can only change on the edge that brings x back to 0.
  vga_mod_counter #(.MOD(V_TOTAL), .W(COORD_W)) u_v_cnt (
    .clk       (clk_25mhz),
    .rst       (rst),
    .en        (h_wrap_s),
    .count     (y_s),
    .count_nxt (y_nxt_s),
    .wrap      (v_wrap_s)
  );

  // decode sync and visible-area flags for the coordinate loaded at the next edge
  always_comb begin
    hsync_nxt_s    = ~SYNC_POL;
    vsync_nxt_s    = ~SYNC_POL;
    video_on_nxt_s = 1'b0;
    if (in_window(x_nxt_s, HS_START, HS_END)) begin
      hsync_nxt_s = SYNC_POL;
    end else begin
      hsync_nxt_s = ~SYNC_POL;
    end
    if (in_window(y_nxt_s, VS_START, VS_END)) begin
      vsync_nxt_s = SYNC_POL;
    end else begin
      vsync_nxt_s = ~SYNC_POL;
    end
    video_on_nxt_s = in_window(x_nxt_s, 0, H_VISIBLE) && in_window(y_nxt_s, 0, V_VISIBLE);
  end

  // flag registers; reset drops any pulse in progress immediately
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      hsync_r    <= ~SYNC_POL;
      vsync_r    <= ~SYNC_POL;
      video_on_r <= 1'b0;
    end else begin
      hsync_r    <= hsync_nxt_s;
      vsync_r    <= vsync_nxt_s;
      video_on_r <= video_on_nxt_s;
    end
  end

  assign vid.hsync    = hsync_r;
  assign vid.vsync    = vsync_r;
  assign vid.video_on = video_on_r;
  assign vid.pix_x    = x_s;
  assign vid.pix_y    = y_s;

`ifdef VGA_FRAME_TICK_EN
  logic frame_tick_r;

  // one-cycle pulse registered together with the move to pix=(0,0)
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= h_wrap_s & v_wrap_s;
    end
  end

  assign vid.frame_tick = frame_tick_r;
`else
  // The vertical wrap only feeds frame_tick.
  logic unused_v_wrap_s;
  assign unused_v_wrap_s = v_wrap_s;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Self-checking bench for vga_sync. Two instances share clock and reset:
// dut_a uses the default 640x480 timing, dut_b a tiny timing with positive
// sync polarity so whole frames (vsync, frame wrap) fit in a short run.
// The reference model tracks a linear pixel index per frame and derives all
// outputs from it with division/modulo.
module tb_vga_sync;
  import vga_timing_pkg::*;

  localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VV = 480, A_VF = 10, A_VS = 2, A_VB = 33;
  localparam int A_FRAME = 800 * 525;

  localparam int B_HV = 16, B_HF = 4, B_HS = 6, B_HB = 6;
  localparam int B_VV = 12, B_VF = 2, B_VS = 2, B_VB = 3;
  localparam int B_HT = 32, B_VT = 19;
  localparam int B_FRAME = B_HT * B_VT;

  typedef struct {
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic vo;
    logic ft;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  vga_sync_if vif_a ();
  vga_sync_if vif_b ();

  vga_sync dut_a (
    .clk_25mhz (clk),
    .rst       (rst),
    .vid       (vif_a)
  );

  vga_sync #(
    .H_VISIBLE (B_HV), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
    .V_VISIBLE (B_VV), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB),
    .SYNC_POL  (1'b1)
  ) dut_b (
    .clk_25mhz (clk),
    .rst       (rst),
    .vid       (vif_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected outputs for linear frame index p under the given timing.
  function automatic exp_t ref_outs(input int p, input bit in_rst,
                                    input int hv, input int hf, input int hs, input int hb,
                                    input int vv, input int vf, input int vs, input int vb,
                                    input logic pol);
    exp_t e;
    int   ht;
    ht  = hv + hf + hs + hb;
    e.x = p % ht;
    e.y = p / ht;
    if (in_rst) begin
      e.vo = 1'b0;
      e.hs = ~pol;
      e.vs = ~pol;
      e.ft = 1'b0;
    end else begin
      e.vo = (e.x < hv) && (e.y < vv);
      e.hs = ((e.x >= hv + hf) && (e.x < hv + hf + hs)) ? pol : ~pol;
      e.vs = ((e.y >= vv + vf) && (e.y < vv + vf + vs)) ? pol : ~pol;
      e.ft = (p == 0);
    end
    return e;
  endfunction

  int   pa = 0;
  int   pb = 0;
  bit   in_rst = 1'b1;
  bit   chk_en = 1'b0;
  exp_t ea;
  exp_t eb;

  // reference model: advance the linear frame index, park it at the last pixel in reset
  always @(posedge clk) begin
    if (rst) begin
      pa     <= A_FRAME - 1;
      pb     <= B_FRAME - 1;
      in_rst <= 1'b1;
    end else begin
      pa     <= (pa + 1) % A_FRAME;
      pb     <= (pb + 1) % B_FRAME;
      in_rst <= 1'b0;
    end
  end

  // per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      ea = ref_outs(pa, in_rst, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, 1'b0);
      eb = ref_outs(pb, in_rst, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, 1'b1);
      check_val("a_x",  32'(vif_a.pix_x),    ea.x);
      check_val("a_y",  32'(vif_a.pix_y),    ea.y);
      check_val("a_hs", 32'(vif_a.hsync),    32'(ea.hs));
      check_val("a_vs", 32'(vif_a.vsync),    32'(ea.vs));
      check_val("a_vo", 32'(vif_a.video_on), 32'(ea.vo));
      check_val("b_x",  32'(vif_b.pix_x),    eb.x);
      check_val("b_y",  32'(vif_b.pix_y),    eb.y);
      check_val("b_hs", 32'(vif_b.hsync),    32'(eb.hs));
      check_val("b_vs", 32'(vif_b.vsync),    32'(eb.vs));
      check_val("b_vo", 32'(vif_b.video_on), 32'(eb.vo));
`ifdef VGA_FRAME_TICK_EN
      check_val("a_ft", 32'(vif_a.frame_tick), 32'(ea.ft));
      check_val("b_ft", 32'(vif_b.frame_tick), 32'(eb.ft));
`endif
    end
  end

  // Wait (bounded) at negedges until the selected instance shows (tx,ty).
  task automatic wait_pos(input bit use_b, input int tx, input int ty, input int budget,
                          input string tag);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (n < budget) begin
      if (use_b) hit = (int'(vif_b.pix_x) == tx) && (int'(vif_b.pix_y) == ty);
      else       hit = (int'(vif_a.pix_x) == tx) && (int'(vif_a.pix_y) == ty);
      if (hit) break;
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(hit), 32'd1);
  endtask

  int hs_low, hs_first, hs_last, vo_cnt, vs_cnt, vs_fx, vs_fy, ft_cnt;

  initial begin
    rst = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);

    // reset state after five reset edges
    check_val("rst_x",   32'(vif_a.pix_x),    32'd799);
    check_val("rst_y",   32'(vif_a.pix_y),    32'd524);
    check_val("rst_vo",  32'(vif_a.video_on), 32'd0);
    check_val("rst_hs",  32'(vif_a.hsync),    32'd1);
    check_val("rst_vs",  32'(vif_a.vsync),    32'd1);
    check_val("rst_bhs", 32'(vif_b.hsync),    32'd0);

    rst = 1'b0;
    @(negedge clk);
    check_val("first_x",  32'(vif_a.pix_x),    32'd0);
    check_val("first_y",  32'(vif_a.pix_y),    32'd0);
    check_val("first_vo", 32'(vif_a.video_on), 32'd1);

    // one full line of dut_a starting at (0,0)
    hs_low = 0; hs_first = -1; hs_last = -1; vo_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (vif_a.hsync === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(vif_a.pix_x);
        hs_last = int'(vif_a.pix_x);
      end
      if (vif_a.video_on === 1'b1) vo_cnt++;
      @(negedge clk);
    end
    check_val("line_hs_cnt",   hs_low,   32'd96);
    check_val("line_hs_first", hs_first, 32'd656);
    check_val("line_hs_last",  hs_last,  32'd751);
    check_val("line_vo_cnt",   vo_cnt,   32'd640);
    check_val("line_period_x", 32'(vif_a.pix_x), 32'd0);
    check_val("line_period_y", 32'(vif_a.pix_y), 32'd1);

    // one full frame of dut_b (positive sync polarity)
    wait_pos(1'b1, 0, 0, B_FRAME + 4, "b_wait_origin");
    vs_cnt = 0; vs_fx = -1; vs_fy = -1; vo_cnt = 0; ft_cnt = 0;
    for (int i = 0; i < B_FRAME; i++) begin
      if (vif_b.vsync === 1'b1) begin
        if (vs_cnt == 0) begin
          vs_fx = int'(vif_b.pix_x);
          vs_fy = int'(vif_b.pix_y);
        end
        vs_cnt++;
      end
      if (vif_b.video_on === 1'b1) vo_cnt++;
`ifdef VGA_FRAME_TICK_EN
      if (vif_b.frame_tick === 1'b1) ft_cnt++;
`endif
      @(negedge clk);
    end
    check_val("b_vs_cnt",   vs_cnt, 32'(B_VS * B_HT));
    check_val("b_vs_fx",    vs_fx,  32'd0);
    check_val("b_vs_fy",    vs_fy,  32'(B_VV + B_VF));
    check_val("b_vo_frame", vo_cnt, 32'(B_HV * B_VV));
    check_val("b_frame_x",  32'(vif_b.pix_x), 32'd0);
    check_val("b_frame_y",  32'(vif_b.pix_y), 32'd0);
`ifdef VGA_FRAME_TICK_EN
    check_val("b_ft_cnt",   ft_cnt, 32'd1);
`endif

    // line wrap (799,10) -> (0,11)
    wait_pos(1'b0, 799, 10, 10000, "a_wait_799_10");
    @(negedge clk);
    check_val("wrap_x", 32'(vif_a.pix_x), 32'd0);
    check_val("wrap_y", 32'(vif_a.pix_y), 32'd11);

    // mid-line reset while hsync is low
    wait_pos(1'b0, 700, 11, 900, "a_wait_700");
    check_val("mid_hs_low", 32'(vif_a.hsync), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_x",  32'(vif_a.pix_x), 32'd799);
    check_val("mid_rst_y",  32'(vif_a.pix_y), 32'd524);
    check_val("mid_rst_hs", 32'(vif_a.hsync), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_val("restart_x",  32'(vif_a.pix_x),    32'd0);
    check_val("restart_y",  32'(vif_a.pix_y),    32'd0);
    check_val("restart_vo", 32'(vif_a.video_on), 32'd1);

    // randomized free-run lengths and reset pulses, checked every cycle by the model
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(20, 2500)) @(negedge clk);
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
    end
    repeat (50) @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
